// File: rtl/dragonfang_floating_point_pkg.sv
// Shared encodings for the vector FP classify pipe: SEW codes, fclass bit
// positions and the sequencing FSM state type.
package dragonfang_floating_point_pkg;

    localparam int VLEN = 128;
    localparam int FCLASS_W = 10;

    typedef enum logic [1:0] {
        SEW_ILLEGAL = 2'b00,
        SEW_16      = 2'b01,
        SEW_32      = 2'b10,
        SEW_64      = 2'b11
    } sew_e;

    // RISC-V fclass one-hot bit positions
    localparam int FC_NEG_INF  = 0;
    localparam int FC_NEG_NORM = 1;
    localparam int FC_NEG_SUB  = 2;
    localparam int FC_NEG_ZERO = 3;
    localparam int FC_POS_ZERO = 4;
    localparam int FC_POS_SUB  = 5;
    localparam int FC_POS_NORM = 6;
    localparam int FC_POS_INF  = 7;
    localparam int FC_SNAN     = 8;
    localparam int FC_QNAN     = 9;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/vector_floating_point_classify_pipe_if.sv
// Request/response bundle of the vector FP classify pipe.
interface vector_floating_point_classify_pipe_if
    import dragonfang_floating_point_pkg::*;
#(
    parameter int VECTOR_LENGTH = VLEN
);
    localparam int VL_W = $clog2(VECTOR_LENGTH / 16) + 1;

    // A transfer happens on a rising clock edge where valid and ready are both 1;
    // valid must not depend on ready, and payload is held while valid&!ready.
    logic                       in_valid;
    logic                       in_ready;
    logic [1:0]                 sew;
    logic [VL_W-1:0]            vl;
    logic                       vm;
    logic [VECTOR_LENGTH/16-1:0] v0;
    logic [VECTOR_LENGTH-1:0]   vs2;
    logic [VECTOR_LENGTH-1:0]   vd_old;
    logic                       out_valid;
    logic                       out_ready;
    logic [VECTOR_LENGTH-1:0]   vd;
    logic                       illegal;

    modport master (
        output in_valid, sew, vl, vm, v0, vs2, vd_old, out_ready,
        input  in_ready, out_valid, vd, illegal
    );

    modport slave (
        input  in_valid, sew, vl, vm, v0, vs2, vd_old, out_ready,
        output in_ready, out_valid, vd, illegal
    );

endinterface

// File: rtl/fp_classify_element.sv
// Classifies one IEEE-754 value of configurable exponent/mantissa width into
// the 10-bit RISC-V fclass one-hot code.
module fp_classify_element
    import dragonfang_floating_point_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0]  value,
    output logic [FCLASS_W-1:0]   fclass
);
    logic             sign;
    logic [EXP_W-1:0] exponent;
    logic [MAN_W-1:0] mantissa;

    assign {sign, exponent, mantissa} = value;

    always_comb begin
        fclass = '0;
        if (&exponent) begin
            // mantissa MSB distinguishes quiet from signalling NaN
            if (mantissa == '0)          fclass[sign ? FC_NEG_INF : FC_POS_INF] = 1'b1;
            else if (mantissa[MAN_W-1])  fclass[FC_QNAN] = 1'b1;
            else                         fclass[FC_SNAN] = 1'b1;
        end else if (exponent == '0) begin
            if (mantissa == '0)          fclass[sign ? FC_NEG_ZERO : FC_POS_ZERO] = 1'b1;
            else                         fclass[sign ? FC_NEG_SUB : FC_POS_SUB] = 1'b1;
        end else begin
            fclass[sign ? FC_NEG_NORM : FC_POS_NORM] = 1'b1;
        end
    end

endmodule

// File: rtl/vector_floating_point_classify_pipe.sv
// Multi-beat vector fclass: captures one request, classifies DATAPATH_WIDTH
// bits per cycle into a result register, then holds the result until taken.
module vector_floating_point_classify_pipe
    import dragonfang_floating_point_pkg::*;
#(
    parameter int VECTOR_LENGTH  = VLEN,
    parameter int DATAPATH_WIDTH = 64
) (
    input  logic   clock,
    input  logic   reset_n,
    vector_floating_point_classify_pipe_if.slave bus,
    output state_t fsm_state
);
    localparam int BEATS  = VECTOR_LENGTH / DATAPATH_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int VL_W   = $clog2(VECTOR_LENGTH / 16) + 1;
    localparam int MASK_W = VECTOR_LENGTH / 16;
    localparam int L16    = DATAPATH_WIDTH / 16;
    localparam int L32    = DATAPATH_WIDTH / 32;
    localparam int L64    = DATAPATH_WIDTH / 64;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_t                    state, state_n;
    logic [BEAT_W-1:0]         beat;
    sew_e                      sew_q;
    logic [VL_W-1:0]           vl_q;
    logic                      vm_q;
    logic [MASK_W-1:0]         v0_q;
    logic [VECTOR_LENGTH-1:0]  vs2_q, vd_old_q, res_q;
    logic                      accept;
    logic [DATAPATH_WIDTH-1:0] src_slice, old_slice, slice_new;
    logic [FCLASS_W-1:0]       cls16 [L16];
    logic [FCLASS_W-1:0]       cls32 [L32];
    logic [FCLASS_W-1:0]       cls64 [L64];

    always_comb begin
        state_n       = state;
        accept        = 1'b0;
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        case (state)
            IDLE: if (bus.in_valid) begin
                accept  = 1'b1;
                state_n = BUSY;
            end
            BUSY: if (beat == LAST_BEAT) state_n = DONE;
            DONE: if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign src_slice = vs2_q[int'(beat) * DATAPATH_WIDTH +: DATAPATH_WIDTH];
    assign old_slice = vd_old_q[int'(beat) * DATAPATH_WIDTH +: DATAPATH_WIDTH];

    for (genvar l = 0; l < L16; l++) begin : g_h
        fp_classify_element #(.EXP_W(5), .MAN_W(10)) u_cls (
            .value(src_slice[l*16 +: 16]), .fclass(cls16[l]));
    end
    for (genvar l = 0; l < L32; l++) begin : g_s
        fp_classify_element #(.EXP_W(8), .MAN_W(23)) u_cls (
            .value(src_slice[l*32 +: 32]), .fclass(cls32[l]));
    end
    for (genvar l = 0; l < L64; l++) begin : g_d
        fp_classify_element #(.EXP_W(11), .MAN_W(52)) u_cls (
            .value(src_slice[l*64 +: 64]), .fclass(cls64[l]));
    end

    // Element indices never exceed VECTOR_LENGTH/SEW-1, so an oversized vl
    // clamps itself; disabled elements and illegal SEW keep vd_old.
    always_comb begin
        int idx;
        idx       = 0;
        slice_new = old_slice;
        case (sew_q)
            SEW_16: for (int l = 0; l < L16; l++) begin
                idx = int'(beat) * L16 + l;
                if (idx < int'(vl_q) && (vm_q || v0_q[idx]))
                    slice_new[l*16 +: 16] = {6'b0, cls16[l]};
            end
            SEW_32: for (int l = 0; l < L32; l++) begin
                idx = int'(beat) * L32 + l;
                if (idx < int'(vl_q) && (vm_q || v0_q[idx]))
                    slice_new[l*32 +: 32] = {22'b0, cls32[l]};
            end
            SEW_64: for (int l = 0; l < L64; l++) begin
                idx = int'(beat) * L64 + l;
                if (idx < int'(vl_q) && (vm_q || v0_q[idx]))
                    slice_new[l*64 +: 64] = {54'b0, cls64[l]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            beat     <= '0;
            sew_q    <= SEW_ILLEGAL;
            vl_q     <= '0;
            vm_q     <= 1'b0;
            v0_q     <= '0;
            vs2_q    <= '0;
            vd_old_q <= '0;
            res_q    <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                sew_q    <= sew_e'(bus.sew);
                vl_q     <= bus.vl;
                vm_q     <= bus.vm;
                v0_q     <= bus.v0;
                vs2_q    <= bus.vs2;
                vd_old_q <= bus.vd_old;
                beat     <= '0;
            end else if (state == BUSY) begin
                res_q[int'(beat) * DATAPATH_WIDTH +: DATAPATH_WIDTH] <= slice_new;
                beat <= beat + BEAT_W'(1);
            end
        end
    end

    assign bus.vd      = res_q;
    assign bus.illegal = (sew_q == SEW_ILLEGAL) && (state == DONE);
    assign fsm_state   = state;

endmodule

// File: tb/tb_vector_floating_point_classify_pipe.sv
// Directed bench for the vector FP classify pipe (VECTOR_LENGTH=128, 2 beats).
module tb_vector_floating_point_classify_pipe;
    import dragonfang_floating_point_pkg::*;

    localparam int W = 128;

    logic   clock;
    logic   reset_n;
    state_t fsm_state;
    int     n_vec;
    int     n_bad;
    logic [W-1:0] exp_q[$];
    logic         exp_ill_q[$];

    vector_floating_point_classify_pipe_if #(.VECTOR_LENGTH(W)) bus ();

    vector_floating_point_classify_pipe #(
        .VECTOR_LENGTH(W),
        .DATAPATH_WIDTH(64)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .bus      (bus),
        .fsm_state(fsm_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic scramble_inputs();
        bus.sew    = 2'($urandom_range(0, 3));
        bus.vl     = 4'($urandom_range(0, 8));
        bus.vm     = 1'($urandom_range(0, 1));
        bus.v0     = 8'($urandom_range(0, 255));
        bus.vs2    = {$urandom, $urandom, $urandom, $urandom};
        bus.vd_old = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Drives one request, checks latency/result, then completes the output handshake
    // after holding out_ready low for hold cycles.
    task automatic send(input string tag, input logic [1:0] sew, input logic [3:0] vl,
                        input logic vm, input logic [7:0] v0, input logic [W-1:0] vs2,
                        input logic [W-1:0] vd_old, input logic [W-1:0] exp_vd,
                        input logic exp_ill, input int hold);
        int lat;
        logic [W-1:0] e_vd;
        logic         e_ill;
        exp_q.push_back(exp_vd);
        exp_ill_q.push_back(exp_ill);
        bus.sew = sew; bus.vl = vl; bus.vm = vm; bus.v0 = v0;
        bus.vs2 = vs2; bus.vd_old = vd_old;
        bus.out_ready = (hold == 0);
        bus.in_valid = 1'b1;
        check({tag, "_in_ready"}, W'(bus.in_ready), W'(1));
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        scramble_inputs();
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        e_vd  = exp_q.pop_front();
        e_ill = exp_ill_q.pop_front();
        check({tag, "_latency"}, W'(lat), W'(3));
        check({tag, "_vd"}, bus.vd, e_vd);
        check({tag, "_illegal"}, W'(bus.illegal), W'(e_ill));
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            check({tag, "_stall_vd"}, bus.vd, e_vd);
            check({tag, "_stall_in_ready"}, W'(bus.in_ready), W'(0));
            check({tag, "_stall_out_valid"}, W'(bus.out_valid), W'(1));
        end
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        check({tag, "_in_ready_after"}, W'(bus.in_ready), W'(1));
        check({tag, "_out_valid_after"}, W'(bus.out_valid), W'(0));
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.sew = '0; bus.vl = '0; bus.vm = 1'b0; bus.v0 = '0;
        bus.vs2 = '0; bus.vd_old = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_vd", bus.vd, '0);
        check("rst_illegal", W'(bus.illegal), W'(0));
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("rst_in_ready", W'(bus.in_ready), W'(1));

        // FP32 specials: +inf, -0, sNaN, qNaN
        send("fp32_special", 2'b10, 4'd4, 1'b1, 8'h00,
             {32'h7FC00000, 32'h7F800001, 32'h80000000, 32'h7F800000},
             '0, {32'h200, 32'h100, 32'h8, 32'h80}, 1'b0, 0);
        // FP64 +subnormal, tail undisturbed
        send("fp64_tail", 2'b11, 4'd1, 1'b1, 8'h00,
             {64'h3FF0000000000000, 64'h0000000000000001},
             {16{8'hAA}}, {64'hAAAAAAAAAAAAAAAA, 64'h20}, 1'b0, 0);
        // FP16 masked by v0=0x55
        send("fp16_mask", 2'b01, 4'd8, 1'b0, 8'h55, {8{16'h3C00}},
             {8{16'hFFFF}}, {4{32'hFFFF0040}}, 1'b0, 0);
        // illegal SEW
        send("illegal_sew", 2'b00, 4'd8, 1'b1, 8'h00, {8{16'h3C00}},
             {4{32'hDEADBEEF}}, {4{32'hDEADBEEF}}, 1'b1, 0);
        // every FP16 class
        send("fp16_all", 2'b01, 4'd8, 1'b1, 8'h00,
             {16'h0200, 16'h7D00, 16'h7E00, 16'h7C00, 16'h0000, 16'h8001, 16'hBC00, 16'hFC00},
             '0,
             {16'h0020, 16'h0100, 16'h0200, 16'h0080, 16'h0010, 16'h0004, 16'h0002, 16'h0001},
             1'b0, 0);
        // vl=0 leaves vd_old
        send("vl_zero", 2'b10, 4'd0, 1'b1, 8'h00, {4{32'h3F800000}},
             {4{32'h13572468}}, {4{32'h13572468}}, 1'b0, 0);
        // vl beyond VLEN/SEW clamps: -inf and -subnormal
        send("fp64_vl_clamp", 2'b11, 4'd8, 1'b1, 8'h00,
             {64'hFFF0000000000000, 64'h8000000000000001},
             '0, {64'h1, 64'h4}, 1'b0, 0);
        // FP32 mask selects element 1 only, vl=2
        send("fp32_mask_tail", 2'b10, 4'd2, 1'b0, 8'h02, {4{32'h3F800000}},
             {4{32'h12345678}}, {32'h12345678, 32'h12345678, 32'h00000040, 32'h12345678},
             1'b0, 0);
        // output backpressure for 5 cycles
        send("stall", 2'b10, 4'd4, 1'b1, 8'h00,
             {32'hBF800000, 32'h00000001, 32'h00000000, 32'hFF800000},
             '0, {32'h2, 32'h20, 32'h10, 32'h1}, 1'b0, 5);

        // reset during BUSY beat 1 of an illegal request
        bus.sew = 2'b00; bus.vl = 4'd8; bus.vm = 1'b1; bus.v0 = '0;
        bus.vs2 = '0; bus.vd_old = {4{32'hCAFEF00D}};
        bus.in_valid = 1'b1;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        @(posedge clock); #1;
        check("midrst_state", W'(fsm_state), W'(BUSY));
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", W'(bus.out_valid), W'(0));
        check("midrst_vd", bus.vd, '0);
        check("midrst_illegal", W'(bus.illegal), W'(0));
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("midrst_in_ready", W'(bus.in_ready), W'(1));
        send("post_reset", 2'b10, 4'd4, 1'b1, 8'h00,
             {32'h7FC00000, 32'h7F800001, 32'h80000000, 32'h7F800000},
             '0, {32'h200, 32'h100, 32'h8, 32'h80}, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vector_floating_point_classify_pipe.md
VECTOR_FLOATING_POINT_CLASSIFY_PIPE -- requirements
Module: vector_floating_point_classify_pipe

Interface
REQ-001 SHALL have parameter VECTOR_LENGTH, default VLEN; register width in bits.
REQ-002 SHALL have parameter DATAPATH_WIDTH, default 64; bits classified per beat; power of two, 64..VECTOR_LENGTH; divides VECTOR_LENGTH.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port sew  input  2  element width; 01=16, 10=32, 11=64, 00=illegal.
REQ-008 SHALL have port vl  input  $clog2(VECTOR_LENGTH/16)+1  active element count.
REQ-009 SHALL have port vm  input  1  1=unmasked, 0=use v0.
REQ-010 SHALL have port v0  input  VECTOR_LENGTH/16  mask bit per element index.
REQ-011 SHALL have port vs2  input  VECTOR_LENGTH  FP source operand.
REQ-012 SHALL have port vd_old  input  VECTOR_LENGTH  prior destination value for undisturbed elements.
REQ-013 SHALL have port out_valid  output  1  result present.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result.
REQ-015 SHALL have port vd  output  VECTOR_LENGTH  classify result.
REQ-016 SHALL have port illegal  output  1  request had sew=00.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, DONE; BEATS = VECTOR_LENGTH/DATAPATH_WIDTH.
REQ-018 in_ready SHALL be 1 only in IDLE; in_valid&in_ready SHALL capture sew, vl, vm, v0, vs2, vd_old and enter BUSY with beat counter 0.
REQ-019 In BUSY each cycle SHALL classify slice [beat*DATAPATH_WIDTH +: DATAPATH_WIDTH] into the result register; after beat BEATS-1 SHALL enter DONE.
REQ-020 out_valid SHALL be 1 exactly in DONE; vd and illegal SHALL stay stable while out_valid&!out_ready.
REQ-021 out_valid&out_ready SHALL return to IDLE; in_ready rises next cycle (no same-cycle re-accept).
REQ-022 Latency SHALL be BEATS+1 cycles from the accept edge to out_valid, for every sew.
REQ-023 Element i of width SEW (FP16/FP32/FP64) SHALL receive the 10-bit RISC-V fclass one-hot, zero-extended to SEW: bit0 -inf, 1 -normal, 2 -subnormal, 3 -0, 4 +0, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN.
REQ-024 Element i SHALL be written only if i<vl and (vm or v0[i]); otherwise SHALL take vd_old element i (mask- and tail-undisturbed).
REQ-025 vl=0 SHALL yield vd=vd_old with normal latency; vl greater than VECTOR_LENGTH/SEW SHALL be treated as VECTOR_LENGTH/SEW.
REQ-026 sew=00 SHALL yield vd=vd_old, illegal=1, normal latency; otherwise illegal=0.
REQ-027 Captured operands SHALL NOT change while BUSY or DONE, regardless of inputs.

Reset
REQ-028 reset_n low SHALL at any time, including mid-BUSY or DONE, force IDLE, beat counter 0, in_ready=1 once reset_n is high, out_valid=0, vd=0, illegal=0, captured registers 0.
REQ-029 The first accept after reset release SHALL behave as for any other request.

Structure
REQ-030 The sew encoding, the fclass bit positions and the FSM state typedef SHALL live in dragonfang_floating_point_pkg.
REQ-031 Per-element classification SHALL be a sub-module fp_classify_element, parametrised by exponent/mantissa widths and instantiated per element lane of one beat for each format.
REQ-032 Result-register update and the FSM SHALL be in the top module; no combinational path from inputs to outputs.

Verification (VECTOR_LENGTH=128, DATAPATH_WIDTH=64, BEATS=2)
REQ-033 sew=10, vl=4, vm=1, vs2 elements {0x7F800000, 0x80000000, 0x7F800001, 0x7FC00000} -> out_valid 3 cycles after accept, vd elements {0x80, 0x8, 0x100, 0x200}, illegal=0.
REQ-034 sew=11, vl=1, vm=1, vs2[63:0]=0x0000000000000001, vd_old all 0xAA -> vd[63:0]=0x20, vd[127:64]=0xAA..AA.
REQ-035 sew=01, vl=8, vm=0, v0=0x55, vs2 all 0x3C00 (+1.0), vd_old all 0xFFFF -> even elements 0x0040, odd elements 0xFFFF.
REQ-036 sew=00, any data -> vd=vd_old, illegal=1, latency 3.
REQ-037 out_ready held 0 for 5 cycles -> vd stable, in_ready=0 throughout; in_ready=1 the cycle after the out handshake.
REQ-038 reset_n pulsed low during BUSY beat 1 -> out_valid=0, vd=0 immediately; next request completes correctly.
